// File: rtl/lstm_bp_pkg.sv
// Shared types and constants for the LSTM BPTT sequencer: FSM states, gate order, fixed-point one.
package lstm_bp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC_H,
    CALC_C,
    CALC_G,
    ACC,
    DONE
  } state_t;

  localparam int unsigned NUM_GATES = 4;
  localparam int unsigned G_A = 0;
  localparam int unsigned G_I = 1;
  localparam int unsigned G_F = 2;
  localparam int unsigned G_O = 3;

  function automatic logic [63:0] fxp_one(input int unsigned frac);
    return 64'd1 << frac;
  endfunction

endpackage

// File: rtl/lstm_bptt_seq_fxp_mul.sv
// Signed fixed-point multiply: full product, arithmetic shift by FRAC, then wrap or clamp.
// Optional feature: BP_SAT_EN selects clamping instead of modulo wrap.
module fxp_mul #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] full;

  assign full = (2*WIDTH)'(a) * (2*WIDTH)'(b);

`ifdef BP_SAT_EN
  logic signed [2*WIDTH-1:0] shr;
  logic fits;

  assign shr  = full >>> FRAC;
  // Result fits when every bit above the WIDTH-1 sign position matches it.
  assign fits = (shr[2*WIDTH-1:WIDTH-1] == '0) || (shr[2*WIDTH-1:WIDTH-1] == '1);
  assign p    = fits ? shr[WIDTH-1:0] : {shr[2*WIDTH-1], {(WIDTH-1){~shr[2*WIDTH-1]}}};
`else
  assign p = WIDTH'(full >>> FRAC);
`endif

endmodule

// File: rtl/lstm_bptt_seq.sv
// Sequential LSTM backprop-through-time gradient engine, steps processed from last to first.
// Optional feature: BP_SAT_EN clamps every product and accumulation instead of wrapping.
module lstm_bptt_seq
  import lstm_bp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24,
  parameter int TIMESTEP = 2,
  parameter int NUM      = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [TIMESTEP*WIDTH-1:0]   i_t, i_h, i_c, i_tc, i_a, i_i, i_f, i_o,
  input  logic [TIMESTEP*NUM*WIDTH-1:0] i_x,
  input  logic [NUM*WIDTH-1:0]        i_wa, i_wi, i_wf, i_wo,
  output logic [4*WIDTH-1:0]          o_b,
  output logic [NUM*WIDTH-1:0]        o_wa, o_wi, o_wf, o_wo,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int KW = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
  localparam int LW = (NUM > 1) ? $clog2(NUM) : 1;

  typedef logic signed [WIDTH-1:0] fx_t;
  localparam fx_t ONE = fx_t'(fxp_one(FRAC));

  function automatic fx_t fadd(input fx_t a, input fx_t b);
`ifdef BP_SAT_EN
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    return (s[WIDTH] != s[WIDTH-1]) ? {s[WIDTH], {(WIDTH-1){~s[WIDTH]}}} : s[WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic fx_t fsub(input fx_t a, input fx_t b);
`ifdef BP_SAT_EN
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    return (s[WIDTH] != s[WIDTH-1]) ? {s[WIDTH], {(WIDTH-1){~s[WIDTH]}}} : s[WIDTH-1:0];
`else
    return a - b;
`endif
  endfunction

  state_t state, state_n;
  logic [KW-1:0] k;
  logic [LW-1:0] lane;

  fx_t h_k, t_k, c_prev, tc_k, a_k, i_k, f_k, o_k, x_kj;
  fx_t dh, dc, dh_next, dc_next, f_next;
  fx_t w_top [NUM_GATES];
  fx_t delta [NUM_GATES];
  fx_t b_acc [NUM_GATES];
  fx_t w_acc [NUM_GATES][NUM];

  fx_t p_dh_tc, p_do1, p_do, p_dh_o, p_tc2, p_dc1, p_carry;
  fx_t p_dc_i, p_a2, p_da, p_dc_a, p_di1, p_di, p_dc_c, p_df1, p_df;
  fx_t p_wx [NUM_GATES];
  fx_t p_wh [NUM_GATES];

  always_comb begin
    h_k    = i_h[int'(k)*WIDTH +: WIDTH];
    t_k    = i_t[int'(k)*WIDTH +: WIDTH];
    tc_k   = i_tc[int'(k)*WIDTH +: WIDTH];
    a_k    = i_a[int'(k)*WIDTH +: WIDTH];
    i_k    = i_i[int'(k)*WIDTH +: WIDTH];
    f_k    = i_f[int'(k)*WIDTH +: WIDTH];
    o_k    = i_o[int'(k)*WIDTH +: WIDTH];
    c_prev = (k == '0) ? '0 : i_c[(int'(k)-1)*WIDTH +: WIDTH];
    x_kj   = i_x[(int'(k)*NUM + int'(lane))*WIDTH +: WIDTH];
  end

  // Only the recurrent lane of each weight vector feeds dh_next.
  assign w_top[G_A] = i_wa[(NUM-1)*WIDTH +: WIDTH];
  assign w_top[G_I] = i_wi[(NUM-1)*WIDTH +: WIDTH];
  assign w_top[G_F] = i_wf[(NUM-1)*WIDTH +: WIDTH];
  assign w_top[G_O] = i_wo[(NUM-1)*WIDTH +: WIDTH];

  if (NUM > 1) begin : g_wlow
    logic unused_wlow;
    assign unused_wlow = ^{i_wa[(NUM-1)*WIDTH-1:0], i_wi[(NUM-1)*WIDTH-1:0],
                           i_wf[(NUM-1)*WIDTH-1:0], i_wo[(NUM-1)*WIDTH-1:0]};
  end

  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_dh_tc (.a(dh),      .b(tc_k),             .p(p_dh_tc));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_do1   (.a(p_dh_tc), .b(o_k),              .p(p_do1));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_do    (.a(p_do1),   .b(fsub(ONE, o_k)),   .p(p_do));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_dh_o  (.a(dh),      .b(o_k),              .p(p_dh_o));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_tc2   (.a(tc_k),    .b(tc_k),             .p(p_tc2));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_dc1   (.a(p_dh_o),  .b(fsub(ONE, p_tc2)), .p(p_dc1));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_carry (.a(dc_next), .b(f_next),           .p(p_carry));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_dc_i  (.a(dc),      .b(i_k),              .p(p_dc_i));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_a2    (.a(a_k),     .b(a_k),              .p(p_a2));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_da    (.a(p_dc_i),  .b(fsub(ONE, p_a2)),  .p(p_da));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_dc_a  (.a(dc),      .b(a_k),              .p(p_dc_a));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_di1   (.a(p_dc_a),  .b(i_k),              .p(p_di1));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_di    (.a(p_di1),   .b(fsub(ONE, i_k)),   .p(p_di));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_dc_c  (.a(dc),      .b(c_prev),           .p(p_dc_c));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_df1   (.a(p_dc_c),  .b(f_k),              .p(p_df1));
  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_df    (.a(p_df1),   .b(fsub(ONE, f_k)),   .p(p_df));

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_wx (.a(delta[g]), .b(x_kj),     .p(p_wx[g]));
    fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_wh (.a(w_top[g]), .b(delta[g]), .p(p_wh[g]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (i_start) state_n = CALC_H;
      CALC_H:  state_n = CALC_C;
      CALC_C:  state_n = CALC_G;
      CALC_G:  state_n = ACC;
      ACC:     if (lane == LW'(NUM-1)) state_n = (k == '0) ? DONE : CALC_H;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);
  assign o_done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k <= '0; lane <= '0;
      dh <= '0; dc <= '0; dh_next <= '0; dc_next <= '0; f_next <= '0;
      for (int unsigned g = 0; g < NUM_GATES; g++) begin
        delta[g] <= '0;
        b_acc[g] <= '0;
        for (int unsigned j = 0; j < NUM; j++) w_acc[g][j] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (i_start) begin
          k <= KW'(TIMESTEP-1); lane <= '0;
          dh <= '0; dc <= '0; dh_next <= '0; dc_next <= '0; f_next <= '0;
          for (int unsigned g = 0; g < NUM_GATES; g++) begin
            delta[g] <= '0;
            b_acc[g] <= '0;
            for (int unsigned j = 0; j < NUM; j++) w_acc[g][j] <= '0;
          end
        end
        CALC_H: dh <= fadd(fsub(h_k, t_k), dh_next);
        CALC_C: begin
          delta[G_O] <= p_do;
          dc         <= fadd(p_dc1, p_carry);
        end
        CALC_G: begin
          delta[G_A] <= p_da;
          delta[G_I] <= p_di;
          delta[G_F] <= p_df;
        end
        ACC: begin
          for (int unsigned g = 0; g < NUM_GATES; g++) begin
            w_acc[g][lane] <= fadd(w_acc[g][lane], p_wx[g]);
            if (lane == '0) b_acc[g] <= fadd(b_acc[g], delta[g]);
          end
          // Carries for the earlier step are latched on the last lane, before k moves.
          if (lane == LW'(NUM-1)) begin
            lane    <= '0;
            dh_next <= fadd(fadd(fadd(p_wh[G_A], p_wh[G_I]), p_wh[G_F]), p_wh[G_O]);
            dc_next <= dc;
            f_next  <= f_k;
            if (k != '0) k <= k - 1'b1;
          end else begin
            lane <= lane + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_b = {b_acc[G_O], b_acc[G_F], b_acc[G_I], b_acc[G_A]};

  for (genvar j = 0; j < NUM; j++) begin : g_out
    assign o_wa[j*WIDTH +: WIDTH] = w_acc[G_A][j];
    assign o_wi[j*WIDTH +: WIDTH] = w_acc[G_I][j];
    assign o_wf[j*WIDTH +: WIDTH] = w_acc[G_F][j];
    assign o_wo[j*WIDTH +: WIDTH] = w_acc[G_O][j];
  end

endmodule

// File: tb/tb_lstm_bptt_seq.sv
// Randomized self-checking bench for lstm_bptt_seq against a step-by-step arithmetic reference.
module tb_lstm_bptt_seq;

  localparam int W   = 32;
  localparam int FR  = 24;
  localparam int TS  = 2;
  localparam int NL  = 3;
  localparam int LAT = TS*(3+NL)+1;
  localparam logic signed [31:0] ONE = 32'h01000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic [TS*W-1:0]    i_t, i_h, i_c, i_tc, i_a, i_i, i_f, i_o;
  logic [TS*NL*W-1:0] i_x;
  logic [NL*W-1:0]    i_wa, i_wi, i_wf, i_wo;
  logic [4*W-1:0]     o_b;
  logic [NL*W-1:0]    o_wa, o_wi, o_wf, o_wo;
  logic               o_busy, o_done;

  lstm_bptt_seq #(.WIDTH(W), .FRAC(FR), .TIMESTEP(TS), .NUM(NL)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_t(i_t), .i_h(i_h), .i_c(i_c), .i_tc(i_tc), .i_a(i_a), .i_i(i_i), .i_f(i_f), .i_o(i_o),
    .i_x(i_x), .i_wa(i_wa), .i_wi(i_wi), .i_wf(i_wf), .i_wo(i_wo),
    .o_b(o_b), .o_wa(o_wa), .o_wi(o_wi), .o_wf(o_wf), .o_wo(o_wo),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic signed [31:0] h_v[TS], t_v[TS], c_v[TS], tc_v[TS], a_v[TS], i_v[TS], f_v[TS], o_v[TS];
  logic signed [31:0] x_v[TS][NL];
  logic signed [31:0] w_v[4][NL];
  logic signed [31:0] exp_b[4];
  logic signed [31:0] exp_w[4][NL];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [31:0] fit(input longint v);
`ifdef BP_SAT_EN
    if (v > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (v < -64'sh80000000) return 32'h80000000;
`endif
    return v[31:0];
  endfunction

  function automatic logic signed [31:0] f_mul(input logic signed [31:0] a, input logic signed [31:0] b);
    return fit((longint'(a) * longint'(b)) >>> FR);
  endfunction

  function automatic logic signed [31:0] f_add(input logic signed [31:0] a, input logic signed [31:0] b);
    return fit(longint'(a) + longint'(b));
  endfunction

  function automatic logic signed [31:0] f_sub(input logic signed [31:0] a, input logic signed [31:0] b);
    return fit(longint'(a) - longint'(b));
  endfunction

  function automatic logic signed [31:0] rnd(input int unsigned span);
    logic signed [31:0] v;
    v = $urandom_range(0, 2*span);
    return v - span;
  endfunction

  task automatic clear_vals;
    for (int k = 0; k < TS; k++) begin
      h_v[k] = '0; t_v[k] = '0; c_v[k] = '0; tc_v[k] = '0;
      a_v[k] = '0; i_v[k] = '0; f_v[k] = '0; o_v[k] = '0;
      for (int j = 0; j < NL; j++) x_v[k][j] = '0;
    end
    for (int g = 0; g < 4; g++) for (int j = 0; j < NL; j++) w_v[g][j] = '0;
  endtask

  task automatic random_vals;
    for (int k = 0; k < TS; k++) begin
      h_v[k] = rnd(32'h01800000); t_v[k] = rnd(32'h01800000); c_v[k] = rnd(32'h02000000);
      tc_v[k] = rnd(32'h00FF0000); a_v[k] = rnd(32'h00FF0000);
      i_v[k] = $urandom_range(0, 32'h00FFFFFF); f_v[k] = $urandom_range(0, 32'h00FFFFFF);
      o_v[k] = $urandom_range(0, 32'h00FFFFFF);
      for (int j = 0; j < NL; j++) x_v[k][j] = rnd(32'h02000000);
    end
    for (int g = 0; g < 4; g++) for (int j = 0; j < NL; j++) w_v[g][j] = rnd(32'h01000000);
  endtask

  task automatic drive_inputs;
    for (int k = 0; k < TS; k++) begin
      i_h[k*W +: W] = h_v[k];   i_t[k*W +: W] = t_v[k];   i_c[k*W +: W] = c_v[k];
      i_tc[k*W +: W] = tc_v[k]; i_a[k*W +: W] = a_v[k];   i_i[k*W +: W] = i_v[k];
      i_f[k*W +: W] = f_v[k];   i_o[k*W +: W] = o_v[k];
      for (int j = 0; j < NL; j++) i_x[(k*NL+j)*W +: W] = x_v[k][j];
    end
    for (int j = 0; j < NL; j++) begin
      i_wa[j*W +: W] = w_v[0][j]; i_wi[j*W +: W] = w_v[1][j];
      i_wf[j*W +: W] = w_v[2][j]; i_wo[j*W +: W] = w_v[3][j];
    end
  endtask

  // Reference: gradient equations evaluated per step, newest step first; gate order a,i,f,o.
  task automatic compute_model;
    logic signed [31:0] dhn, dcn, fn, dh, dc, cp;
    logic signed [31:0] d[4];
    dhn = '0; dcn = '0; fn = '0;
    for (int g = 0; g < 4; g++) begin
      exp_b[g] = '0;
      for (int j = 0; j < NL; j++) exp_w[g][j] = '0;
    end
    for (int k = TS-1; k >= 0; k--) begin
      dh   = f_add(f_sub(h_v[k], t_v[k]), dhn);
      d[3] = f_mul(f_mul(f_mul(dh, tc_v[k]), o_v[k]), f_sub(ONE, o_v[k]));
      dc   = f_add(f_mul(f_mul(dh, o_v[k]), f_sub(ONE, f_mul(tc_v[k], tc_v[k]))), f_mul(dcn, fn));
      cp   = (k == 0) ? 32'sd0 : c_v[k-1];
      d[0] = f_mul(f_mul(dc, i_v[k]), f_sub(ONE, f_mul(a_v[k], a_v[k])));
      d[1] = f_mul(f_mul(f_mul(dc, a_v[k]), i_v[k]), f_sub(ONE, i_v[k]));
      d[2] = f_mul(f_mul(f_mul(dc, cp), f_v[k]), f_sub(ONE, f_v[k]));
      dhn = '0;
      for (int g = 0; g < 4; g++) begin
        exp_b[g] = f_add(exp_b[g], d[g]);
        for (int j = 0; j < NL; j++) exp_w[g][j] = f_add(exp_w[g][j], f_mul(d[g], x_v[k][j]));
        dhn = f_add(dhn, f_mul(w_v[g][NL-1], d[g]));
      end
      dcn = dc;
      fn  = f_v[k];
    end
  endtask

  function automatic logic [NL*W-1:0] wout(input int g);
    case (g)
      0: return o_wa;
      1: return o_wi;
      2: return o_wf;
      default: return o_wo;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    logic [NL*W-1:0] wv;
    for (int g = 0; g < 4; g++) begin
      check_val($sformatf("%s_b%0d", tag, g), o_b[g*W +: W], exp_b[g]);
      wv = wout(g);
      for (int j = 0; j < NL; j++)
        check_val($sformatf("%s_w%0d_%0d", tag, g, j), wv[j*W +: W], exp_w[g][j]);
    end
  endtask

  task automatic wait_done(output int edges);
    edges = 1;
    while (!o_done && edges < 200) begin
      tick;
      edges++;
    end
  endtask

  task automatic run(input string tag, input bit glitch);
    int edges;
    int pulses;
    drive_inputs();
    compute_model();
    i_start = 1'b1;
    tick;
    edges = 1;
    while (!o_done && edges < 200) begin
      i_start = glitch && (edges < 3 || edges == 7);
      tick;
      edges++;
    end
    i_start = 1'b0;
    check_val({tag, "_lat"}, edges, LAT);
    check_outputs(tag);
    tick;
    check_val({tag, "_pulse"}, {31'd0, o_done}, 32'd0);
    check_val({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
    pulses = 0;
    for (int n = 0; n < 25; n++) begin
      tick;
      if (o_done) pulses++;
    end
    check_val({tag, "_extra"}, pulses, 0);
    check_val({tag, "_hold"}, o_b[3*W +: W], exp_b[3]);
  endtask

  initial begin
    int edges;
    int pulses;
    clear_vals();
    drive_inputs();
    #3 rst = 1'b0;
    #9;
    check_val("rst_busy", {31'd0, o_busy}, 32'd0);
    check_val("rst_done", {31'd0, o_done}, 32'd0);
    check_val("rst_bo", o_b[3*W +: W], 32'd0);
    check_val("rst_wa0", o_wa[0 +: W], 32'd0);
    rst = 1'b1;
    tick;

    // Hand-computed case: only step 0 active.
    clear_vals();
    h_v[0] = 32'h01000000; t_v[0] = 32'h00800000;
    o_v[0] = 32'h00800000; tc_v[0] = 32'h00800000; i_v[0] = 32'h00800000;
    x_v[0][0] = 32'h01000000; x_v[0][1] = 32'h02000000;
    run("dir", 1'b0);
    check_val("dir_bo", o_b[3*W +: W], 32'h00100000);
    check_val("dir_bf", o_b[2*W +: W], 32'h00000000);
    check_val("dir_bi", o_b[1*W +: W], 32'h00000000);
    check_val("dir_ba", o_b[0*W +: W], 32'h00180000);
    check_val("dir_wo0", o_wo[0*W +: W], 32'h00100000);
    check_val("dir_wo1", o_wo[1*W +: W], 32'h00200000);

    // h - t overflows at the newest step.
    clear_vals();
    h_v[1] = 32'h7F000000; t_v[1] = 32'h81000000;
    o_v[1] = 32'h00800000; tc_v[1] = 32'h00800000;
    run("ovf", 1'b0);
`ifdef BP_SAT_EN
    check_val("ovf_bo", o_b[3*W +: W], 32'h0FFFFFFF);
`else
    check_val("ovf_bo", o_b[3*W +: W], 32'hFFC00000);
`endif

    for (int r = 0; r < 6; r++) begin
      random_vals();
      run($sformatf("rnd%0d", r), r == 2);
    end

    // Back-to-back: start raised during DONE, accepted one cycle later with fresh inputs.
    random_vals();
    drive_inputs();
    compute_model();
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    wait_done(edges);
    check_val("b2b1_lat", edges, LAT);
    check_outputs("b2b1");
    random_vals();
    drive_inputs();
    compute_model();
    i_start = 1'b1;
    tick;
    check_val("b2b_done_ign", {31'd0, o_busy}, 32'd0);
    tick;
    i_start = 1'b0;
    check_val("b2b_accept", {31'd0, o_busy}, 32'd1);
    check_val("b2b_clr_bo", o_b[3*W +: W], 32'd0);
    check_val("b2b_clr_wa", o_wa[0 +: W], 32'd0);
    wait_done(edges);
    check_val("b2b2_lat", edges, LAT);
    check_outputs("b2b2");
    tick;

    // Reset asserted in the middle of the accumulate phase.
    random_vals();
    drive_inputs();
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    for (int n = 0; n < 4; n++) tick;
    #2 rst = 1'b0;
    #1;
    check_val("mrst_busy", {31'd0, o_busy}, 32'd0);
    check_val("mrst_done", {31'd0, o_done}, 32'd0);
    check_val("mrst_bo", o_b[3*W +: W], 32'd0);
    check_val("mrst_ba", o_b[0*W +: W], 32'd0);
    check_val("mrst_wo", o_wo[0 +: W], 32'd0);
    tick;
    check_val("mrst_busy2", {31'd0, o_busy}, 32'd0);
    rst = 1'b1;
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      tick;
      if (o_done) pulses++;
    end
    check_val("mrst_nodone", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
